// File: rtl/div_timer.sv
// Free-running system divider plus a programmable interval timer (DIV/TIMA/TMA/TAC)
// on an 8-bit register bus. TIMA counts falling edges of a selected divider tap.
module div_timer #(
    parameter int DIV_W      = 16,
    parameter int TIMER_W    = 8,
    parameter int TAP0       = 9,
    parameter int TAP1       = 3,
    parameter int TAP2       = 5,
    parameter int TAP3       = 7,
    parameter int RELOAD_DLY = 4,
    parameter int DIV_RD_LSB = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             stop,
    input  logic [1:0]       addr,
    input  logic             wr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic [DIV_W-1:0] div_q,
    output logic             irq
);

    typedef enum logic [1:0] {IDLE, DELAY, RELOAD} state_t;

    localparam int CNT_W = (RELOAD_DLY > 2) ? $clog2(RELOAD_DLY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((RELOAD_DLY > 0) ? RELOAD_DLY - 1 : 0);

    logic [DIV_W-1:0]   div;
    logic [TIMER_W-1:0] tima, tima_n;
    logic [TIMER_W-1:0] tma;
    logic [2:0]         tac;
    logic               sel_d, sel_now, tap, tick;
    logic [CNT_W-1:0]   cnt, cnt_n;
    state_t             state, state_n;

    logic wr_div, wr_tima, wr_tma, wr_tac;
    assign wr_div  = wr && (addr == 2'd0);
    assign wr_tima = wr && (addr == 2'd1);
    assign wr_tma  = wr && (addr == 2'd2);
    assign wr_tac  = wr && (addr == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div <= '0;
        else if (wr_div)
            div <= '0;
        else if (ce && !stop)
            div <= div + DIV_W'(1);
    end

    always_comb begin
        case (tac[1:0])
            2'd0:    tap = div[TAP0];
            2'd1:    tap = div[TAP1];
            2'd2:    tap = div[TAP2];
            default: tap = div[TAP3];
        endcase
    end

    // Falling-edge detect on the gated tap; DIV clears and TAC changes that drop
    // sel_now also count as ticks, which is the intended behaviour.
    assign sel_now = tap & tac[2];
    assign tick    = sel_d & ~sel_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_d <= 1'b0;
            tma   <= '0;
            tac   <= '0;
        end else begin
            sel_d <= sel_now;
            if (wr_tma) tma <= wdata[TIMER_W-1:0];
            if (wr_tac) tac <= wdata[2:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tima  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            tima  <= tima_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        tima_n  = tima;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (wr_tima)
                    tima_n = wdata[TIMER_W-1:0];
                else if (tick) begin
                    if (&tima) begin
                        tima_n  = '0;
                        cnt_n   = '0;
                        state_n = (RELOAD_DLY == 0) ? RELOAD : DELAY;
                    end else
                        tima_n = tima + TIMER_W'(1);
                end
            end
            DELAY: begin
                // A TIMA write here cancels the pending reload and its irq.
                if (wr_tima) begin
                    tima_n  = wdata[TIMER_W-1:0];
                    state_n = IDLE;
                end else begin
                    if (tick) tima_n = tima + TIMER_W'(1);
                    if (ce) begin
                        if (cnt == CNT_LAST) state_n = RELOAD;
                        else                 cnt_n   = cnt + CNT_W'(1);
                    end
                end
            end
            RELOAD: begin
                tima_n  = wr_tma ? wdata[TIMER_W-1:0] : tma;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign irq   = (state == RELOAD);
    assign div_q = div;

    always_comb begin
        rdata = 8'h00;
        case (addr)
            2'd0: rdata = div[DIV_RD_LSB +: 8];
            2'd1: rdata[TIMER_W-1:0] = tima;
            2'd2: rdata[TIMER_W-1:0] = tma;
            2'd3: rdata = {5'b11111, tac};
        endcase
    end

endmodule
